// File: rtl/bus_arbiter8_pkg.sv
// Shared constants, FSM state type and parameter checks for the 8-way bus arbiter.
package bus_arbiter8_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // A burst limit must be at least one beat and fit in the beat counter.
    function automatic bit beats_ok(input int max_beats);
        return (max_beats >= 1) && (max_beats < (1 << CNT_W));
    endfunction

endpackage

// File: rtl/bus_arbiter8_if.sv
// Requester/consumer side of the arbiter: request vector, data words, and the output beat channel.
interface bus_arbiter8_if
    import bus_arbiter8_pkg::*;
#(
    parameter int WIDTH = 16
) ();

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] data_in;
    logic                   out_ready;
    logic [N_REQ-1:0]       grant;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic [IDX_W-1:0]       out_src;
    logic                   busy;

    // Requesters and the bus consumer.
    modport master (
        output req, data_in, out_ready,
        input  grant, out_valid, out_data, out_src, busy
    );

    // The arbiter itself.
    modport slave (
        input  req, data_in, out_ready,
        output grant, out_valid, out_data, out_src, busy
    );

endinterface

// File: rtl/bus_arbiter8_rr_pick8.sv
// Round-robin pick: first requester after last_idx, wrapping, so last_idx itself has lowest priority.
module rr_pick8
    import bus_arbiter8_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_idx,
    output logic [IDX_W-1:0] pick_idx,
    output logic             any_req
);

    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;

    // Rotate so bit 0 is the requester after last_idx, encode the lowest set bit, rotate back.
    always_comb begin
        rot = '0;
        off = '0;
        for (int k = 0; k < N_REQ; k++) begin
            rot[k] = req[IDX_W'(last_idx + IDX_W'(k) + IDX_W'(1))];
        end
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) off = IDX_W'(k);
        end
        pick_idx = last_idx + IDX_W'(1) + off;
        any_req  = |req;
    end

endmodule

// File: rtl/bus_arbiter8.sv
// Round-robin arbiter: one owner at a time forwards its word on a valid/ready channel,
// ownership rotates on withdrawal or after MAX_BEATS accepted beats.
module bus_arbiter8
    import bus_arbiter8_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MAX_BEATS = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    bus_arbiter8_if.slave  bus
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

    if (!beats_ok(MAX_BEATS)) begin : g_bad_max_beats
        $error("bus_arbiter8: MAX_BEATS must be in 1..15");
    end

    state_t           state;
    logic [IDX_W-1:0] last_idx;
    logic [IDX_W-1:0] out_src;
    logic [CNT_W-1:0] beat_cnt;
    logic [N_REQ-1:0] grant;
    logic             out_valid;
    logic             busy;

    logic [IDX_W-1:0] pick_last;
    logic [IDX_W-1:0] pick_idx;
    logic             any_req;
    logic             xfer;
    logic [CNT_W-1:0] cnt_next;
    logic             release_now;

    // While an owner holds the bus, the pick for a same-edge rotation starts after that owner.
    always_comb begin
        pick_last   = (state == GRANT) ? out_src : last_idx;
        xfer        = out_valid & bus.out_ready;
        cnt_next    = beat_cnt + CNT_W'(xfer);
        release_now = (state == GRANT) &&
                      (!bus.req[out_src] || (xfer && (cnt_next == MAX_CNT)));
    end

    rr_pick8 u_pick (
        .req      (bus.req),
        .last_idx (pick_last),
        .pick_idx (pick_idx),
        .any_req  (any_req)
    );

    // Arbitration FSM: grant from IDLE, count beats, release and rotate without an idle bubble.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            last_idx  <= IDX_W'(N_REQ - 1);
            out_src   <= '0;
            beat_cnt  <= '0;
            grant     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state     <= GRANT;
                        grant     <= N_REQ'(1) << pick_idx;
                        out_src   <= pick_idx;
                        beat_cnt  <= '0;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        last_idx <= out_src;
                        beat_cnt <= '0;
                        if (any_req) begin
                            grant   <= N_REQ'(1) << pick_idx;
                            out_src <= pick_idx;
                        end else begin
                            state     <= IDLE;
                            grant     <= '0;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                        end
                    end else begin
                        beat_cnt <= cnt_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs: registered control, data muxed from the registered owner index and zero when idle.
    always_comb begin
        bus.grant     = grant;
        bus.out_valid = out_valid;
        bus.out_src   = out_src;
        bus.busy      = busy;
        bus.out_data  = out_valid ? bus.data_in[out_src*WIDTH +: WIDTH] : '0;
    end

endmodule

// File: tb/tb_bus_arbiter8.sv
// Directed bench for bus_arbiter8: stimulus pushes expected beats, a negedge monitor checks them.
module tb_bus_arbiter8;

    localparam int W = 16;

    typedef struct {
        logic [2:0]   src;
        logic [W-1:0] data;
    } beat_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    beat_t exp_q[$];

    bus_arbiter8_if #(.WIDTH(W)) bus ();

    bus_arbiter8 #(.WIDTH(W), .MAX_BEATS(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [W-1:0] word(input int i);
        return W'(16'hA000 + i * 16'h0111);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input int src, input int n);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.src  = 3'(src);
            b.data = word(src);
            exp_q.push_back(b);
        end
    endtask

    task automatic set_word(input int i, input logic [W-1:0] w);
        bus.data_in[i*W +: W] = w;
    endtask

    // Monitor: every beat accepted at the coming edge must match the head of the queue.
    initial begin
        beat_t e;
        forever begin
            @(negedge clock);
            if (reset_n && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got src %0d data %h expected none", bus.out_src, bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_src", 32'(bus.out_src), 32'(e.src));
                    chk("beat_data", 32'(bus.out_data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) set_word(i, word(i));

        // 1: reset values, then single request granted one cycle later
        #12;
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_src", 32'(bus.out_src), 32'h0);
        chk("rst_data", 32'(bus.out_data), 32'h0);
        step();
        reset_n = 1'b1;
        bus.req = 8'h01;
        step();
        chk("t1_grant", 32'(bus.grant), 32'h01);
        chk("t1_src", 32'(bus.out_src), 32'h0);
        chk("t1_valid", 32'(bus.out_valid), 32'h1);
        chk("t1_data", 32'(bus.out_data), 32'(word(0)));
        bus.req = 8'h00;
        step();
        chk("t1_idle", 32'(bus.grant), 32'h0);

        // 2: all requesting, full rotation 0..7,0 with 4 beats each and no gaps
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        for (int g = 0; g < 9; g++) push(g % 8, 4);
        bus.req = 8'hFF;
        bus.out_ready = 1'b1;
        step();
        for (int g = 0; g < 9; g++) begin
            for (int b = 0; b < 4; b++) begin
                chk("t2_grant", 32'(bus.grant), 32'(8'h01 << (g % 8)));
                chk("t2_valid", 32'(bus.out_valid), 32'h1);
                step();
            end
        end
        chk("t2_next_owner", 32'(bus.grant), 32'h02);
        bus.req = 8'h00;
        bus.out_ready = 1'b0;
        step();
        chk("t2_idle", 32'(bus.busy), 32'h0);

        // 3: owner 3 withdraws while 2 and 5 request -> 5, then withdrawal of 5 with a beat -> 2
        bus.req = 8'h08;
        step();
        chk("t3_grant3", 32'(bus.grant), 32'h08);
        bus.req = 8'h24;
        step();
        chk("t3_grant5", 32'(bus.grant), 32'h20);
        push(5, 2);
        bus.out_ready = 1'b1;
        step();
        chk("t3_still5", 32'(bus.grant), 32'h20);
        bus.req = 8'h04;
        step();
        bus.out_ready = 1'b0;
        chk("t3_grant2", 32'(bus.grant), 32'h04);
        chk("t3_src2", 32'(bus.out_src), 32'h2);

        // 4: stalled consumer, grant stable and data follows the owner's slice
        for (int k = 0; k < 10; k++) begin
            set_word(2, W'(16'h5A00 + k));
            #1;
            chk("t4_grant", 32'(bus.grant), 32'h04);
            chk("t4_valid", 32'(bus.out_valid), 32'h1);
            chk("t4_cnt", 32'(dut.beat_cnt), 32'h0);
            chk("t4_data", 32'(bus.out_data), 32'(16'h5A00 + k));
            step();
        end
        set_word(2, word(2));

        // 5: async reset mid-burst, then priority restarts at requester 0
        push(2, 2);
        bus.out_ready = 1'b1;
        step();
        step();
        bus.out_ready = 1'b0;
        chk("t5_cnt", 32'(dut.beat_cnt), 32'h2);
        bus.req = 8'h81;
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_grant", 32'(bus.grant), 32'h0);
        chk("t5_valid", 32'(bus.out_valid), 32'h0);
        chk("t5_busy", 32'(bus.busy), 32'h0);
        chk("t5_data", 32'(bus.out_data), 32'h0);
        chk("t5_src", 32'(bus.out_src), 32'h0);
        step();
        reset_n = 1'b1;
        step();
        chk("t5_first", 32'(bus.grant), 32'h01);
        bus.req = 8'h00;
        step();
        chk("t5_idle", 32'(bus.grant), 32'h0);

        // 6: lone requester 3 re-granted after each burst with no gap
        push(3, 12);
        bus.req = 8'h08;
        bus.out_ready = 1'b1;
        step();
        for (int k = 0; k < 12; k++) begin
            chk("t6_grant", 32'(bus.grant), 32'h08);
            chk("t6_valid", 32'(bus.out_valid), 32'h1);
            step();
        end
        bus.req = 8'h00;
        bus.out_ready = 1'b0;
        step();
        chk("t6_idle", 32'(bus.grant), 32'h0);

        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
